// File: rtl/spi_register_bank.sv
// spi_register_bank
//   SPI-slave (mode 0, MSB first) write-only front end feeding five 8-bit
//   control registers that drive the PWM peripheral.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, copi, ncs     SPI pins, asynchronous to clk
//   en_reg_out_7_0      register 0x00
//   en_reg_out_15_8     register 0x01
//   en_reg_pwm_7_0      register 0x02
//   en_reg_pwm_15_8     register 0x03
//   pwm_duty_cycle      register 0x04
//   frame_done          one-cycle pulse on a committed write
//   frame_err           one-cycle pulse on a discarded malformed frame
module spi_register_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [6:0] LP_MAX_ADDR = 7'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic       r_sclk_d, r_copi_d, r_ncs_d;
    logic       r_sclk_rise, r_ncs_rise, r_ncs_fall;
    logic       r_fall_pend;
    logic [4:0] r_cnt;
    logic [15:0] r_shift;
    logic [7:0] r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;
    logic       r_done, r_err;
    state_t     r_state, w_next;

    logic w_sclk_s, w_copi_s, w_ncs_s;
    logic w_start;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];

    // A falling ncs edge that lands while COMMIT is busy is remembered so the
    // next frame still starts from IDLE.
    assign w_start = r_ncs_fall | r_fall_pend;

    // Synchronisers, one delay register, and registered edge pulses. The
    // copi delay register lines up with the sclk rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_d    <= 1'b0;
            r_copi_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
            r_sclk_rise <= 1'b0;
            r_ncs_rise  <= 1'b0;
            r_ncs_fall  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_d    <= w_sclk_s;
            r_copi_d    <= w_copi_s;
            r_ncs_d     <= w_ncs_s;
            r_sclk_rise <= w_sclk_s & ~r_sclk_d;
            r_ncs_rise  <= w_ncs_s & ~r_ncs_d;
            r_ncs_fall  <= ~w_ncs_s & r_ncs_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = SHIFT;
            SHIFT:   if (r_ncs_rise) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bit counter and shift register. Counter stops at 17 (overlong marker);
    // only the first 16 bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_fall_pend <= 1'b0;
        end else begin
            if (r_state == COMMIT && r_ncs_fall) r_fall_pend <= 1'b1;
            else if (r_state == IDLE)            r_fall_pend <= 1'b0;

            if (r_state == IDLE && w_start) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (r_state == SHIFT && !r_ncs_rise && r_sclk_rise && !r_ncs_d) begin
                if (r_cnt < 5'd16) r_shift <= {r_shift[14:0], r_copi_d};
                if (r_cnt < 5'd17) r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Commit: only a 16-bit write to a valid address updates a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg0 <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
            r_reg3 <= '0;
            r_reg4 <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == COMMIT) begin
                if (r_cnt == 5'd16 && !r_shift[15]) begin
                    // read frame: silently ignored
                end else if (r_cnt == 5'd16 && r_shift[14:8] <= LP_MAX_ADDR) begin
                    r_done <= 1'b1;
                    case (r_shift[14:8])
                        7'd0:    r_reg0 <= r_shift[7:0];
                        7'd1:    r_reg1 <= r_shift[7:0];
                        7'd2:    r_reg2 <= r_shift[7:0];
                        7'd3:    r_reg3 <= r_shift[7:0];
                        7'd4:    r_reg4 <= r_shift[7:0];
                        default: ;
                    endcase
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign en_reg_out_7_0  = r_reg0;
    assign en_reg_out_15_8 = r_reg1;
    assign en_reg_pwm_7_0  = r_reg2;
    assign en_reg_pwm_15_8 = r_reg3;
    assign pwm_duty_cycle  = r_reg4;
    assign frame_done      = r_done;
    assign frame_err       = r_err;

endmodule
